// File: rtl/usb_hid_kbd_report_gen_if.sv
// Key-event input and EP81 IN byte-stream handshake of the HID keyboard report generator.
// slave = generator side, master = key source / endpoint side.
interface usb_hid_kbd_report_gen_if;
  logic [15:0] key_value;
  logic        key_request;
  logic        key_ready;
  logic [7:0]  ep_data;
  logic        ep_valid;
  logic        ep_ready;

  modport slave  (input  key_value, key_request, ep_ready,
                  output key_ready, ep_data, ep_valid);
  modport master (output key_value, key_request, ep_ready,
                  input  key_ready, ep_data, ep_valid);
endinterface

// File: rtl/usb_hid_kbd_report_gen.sv
// HID boot-keyboard report generator: queues key events and streams one press report
// followed by one all-zero release report per event onto the EP81 IN byte stream.
module usb_hid_kbd_report_gen #(
  parameter int NKEY        = 6,
  parameter int FIFO_DEPTH  = 16,
  parameter int RELEASE_GAP = 0,
  parameter int DROP_W      = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    usb_rstn,
  usb_hid_kbd_report_gen_if.slave kbd,
  output logic                    busy,
  output logic [DROP_W-1:0]       drop_cnt
);
  localparam int RLEN = 2 + NKEY;
  localparam int IW   = $clog2(RLEN);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int GW   = (RELEASE_GAP > 1) ? $clog2(RELEASE_GAP) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_PRESS, S_GAP, S_REL} state_e;

  logic [15:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              full, empty, push, pop;

  state_e            state_q;
  logic [15:0]       hold_q;
  logic [IW-1:0]     idx_q, idx_nx;
  logic [GW-1:0]     gap_q;
  logic              ep_valid_q;
  logic [7:0]        ep_data_q;
  logic              last;

  function automatic logic [7:0] press_byte(input logic [15:0] ev, input logic [IW-1:0] i);
    if (i == '0)      return ev[15:8];
    if (i == IW'(2))  return ev[7:0];
    return 8'h00;
  endfunction

  // full is taken from the registered count, so a same-cycle pop never frees a slot
  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign push  = usb_rstn && kbd.key_request && !full;
  assign pop   = usb_rstn && (state_q == S_IDLE) && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    drop_d   = drop_q;
    if (usb_rstn && kbd.key_request && full && (drop_q != '1))
      drop_d = drop_q + DROP_W'(1);
    if (!usb_rstn) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      drop_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= kbd.key_value;
  end

  assign last   = (idx_q == IW'(RLEN-1));
  assign idx_nx = last ? '0 : idx_q + IW'(1);

  // PRESS spends its first cycle loading b0, which gives the two-cycle push-to-valid latency
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      hold_q     <= '0;
      idx_q      <= '0;
      gap_q      <= '0;
      ep_valid_q <= 1'b0;
      ep_data_q  <= '0;
    end else if (!usb_rstn) begin
      state_q    <= S_IDLE;
      hold_q     <= '0;
      idx_q      <= '0;
      gap_q      <= '0;
      ep_valid_q <= 1'b0;
      ep_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            hold_q  <= mem_q[rd_ptr_q];
            idx_q   <= '0;
            state_q <= S_PRESS;
          end
        end
        S_PRESS: begin
          if (!ep_valid_q) begin
            ep_valid_q <= 1'b1;
            ep_data_q  <= press_byte(hold_q, idx_q);
          end else if (kbd.ep_ready) begin
            idx_q <= idx_nx;
            if (last) begin
              ep_data_q <= 8'h00;
              if (RELEASE_GAP > 0) begin
                state_q    <= S_GAP;
                ep_valid_q <= 1'b0;
                gap_q      <= '0;
              end else begin
                state_q    <= S_REL;
              end
            end else begin
              ep_data_q <= press_byte(hold_q, idx_nx);
            end
          end
        end
        S_GAP: begin
          if (gap_q == GW'(RELEASE_GAP-1)) begin
            state_q    <= S_REL;
            ep_valid_q <= 1'b1;
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        S_REL: begin
          if (kbd.ep_ready) begin
            idx_q <= idx_nx;
            if (last) begin
              state_q    <= S_IDLE;
              ep_valid_q <= 1'b0;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign kbd.ep_valid  = ep_valid_q;
  assign kbd.ep_data   = ep_data_q;
  assign kbd.key_ready = !full;
  assign busy          = !empty || (state_q != S_IDLE);
  assign drop_cnt      = drop_q;
endmodule

// File: tb/tb_usb_hid_kbd_report_gen.sv
// Bench for usb_hid_kbd_report_gen: a default instance (a) and a small instance (b) with
// NKEY=2, FIFO_DEPTH=4, RELEASE_GAP=3, DROP_W=2, checked against a report-level model.
module tb_usb_hid_kbd_report_gen;
  localparam int RLEN_A  = 8;
  localparam int RLEN_B  = 4;
  localparam int DEPTH_B = 4;
  localparam int GAP_B   = 3;
  localparam int DMAX_B  = 3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic usb_rstn_a = 1'b1;
  logic usb_rstn_b = 1'b1;
  logic       busy_a, busy_b;
  logic [7:0] drop_a;
  logic [1:0] drop_b;

  int total = 0;
  int bad   = 0;
  int dropm_b = 0;

  logic [7:0] qa[$], qb[$], expa[$], expb[$];
  bit         hold_a = 1'b0, hold_b = 1'b0;
  logic [7:0] hold_da = '0, hold_db = '0;

  always #5 clk = ~clk;

  usb_hid_kbd_report_gen_if ia ();
  usb_hid_kbd_report_gen_if ib ();

  usb_hid_kbd_report_gen dut_a (
    .clk(clk), .rstn(rstn), .usb_rstn(usb_rstn_a), .kbd(ia),
    .busy(busy_a), .drop_cnt(drop_a)
  );

  usb_hid_kbd_report_gen #(.NKEY(2), .FIFO_DEPTH(4), .RELEASE_GAP(3), .DROP_W(2)) dut_b (
    .clk(clk), .rstn(rstn), .usb_rstn(usb_rstn_b), .kbd(ib),
    .busy(busy_b), .drop_cnt(drop_b)
  );

  // Endpoint monitors: capture transferred bytes and check data is held while stalled.
  always @(negedge clk) begin
    if (hold_a) begin
      total++;
      if (ia.ep_valid !== 1'b1 || ia.ep_data !== hold_da) begin
        bad++;
        $display("FAIL hold_a: valid=%b data=%h, need valid=1 data=%h", ia.ep_valid, ia.ep_data, hold_da);
      end
    end
    if (ia.ep_valid === 1'b1 && ia.ep_ready === 1'b1) qa.push_back(ia.ep_data);
    hold_a  = (ia.ep_valid === 1'b1) && (ia.ep_ready === 1'b0) && usb_rstn_a;
    hold_da = ia.ep_data;
  end

  always @(negedge clk) begin
    if (hold_b) begin
      total++;
      if (ib.ep_valid !== 1'b1 || ib.ep_data !== hold_db) begin
        bad++;
        $display("FAIL hold_b: valid=%b data=%h, need valid=1 data=%h", ib.ep_valid, ib.ep_data, hold_db);
      end
    end
    if (ib.ep_valid === 1'b1 && ib.ep_ready === 1'b1) qb.push_back(ib.ep_data);
    hold_b  = (ib.ep_valid === 1'b1) && (ib.ep_ready === 1'b0) && usb_rstn_b;
    hold_db = ib.ep_data;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: a press report {mod,00,key,00..} then an all-zero release report per event.
  task automatic add_exp(input bit b, input logic [15:0] kv);
    int rl;
    logic [7:0] v;
    rl = b ? RLEN_B : RLEN_A;
    for (int i = 0; i < 2*rl; i++) begin
      v = (i == 0) ? kv[15:8] : (i == 2) ? kv[7:0] : 8'h00;
      if (b) expb.push_back(v);
      else   expa.push_back(v);
    end
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (ia.ep_valid !== 1'b0 || ia.ep_data !== 8'h00 || ia.key_ready !== 1'b1 || busy_a !== 1'b0 || drop_a !== 8'h00) begin
      bad++;
      $display("FAIL reset_a: valid=%b data=%h kr=%b busy=%b drop=%h, need 0 00 1 0 00",
               ia.ep_valid, ia.ep_data, ia.key_ready, busy_a, drop_a);
    end
    total++;
    if (ib.ep_valid !== 1'b0 || ib.ep_data !== 8'h00 || ib.key_ready !== 1'b1 || busy_b !== 1'b0 || drop_b !== 2'd0) begin
      bad++;
      $display("FAIL reset_b: valid=%b data=%h kr=%b busy=%b drop=%h, need 0 00 1 0 0",
               ib.ep_valid, ib.ep_data, ib.key_ready, busy_b, drop_b);
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    step(2);
  endtask

  task automatic test_single_press();
    int n;
    qa.delete(); expa.delete();
    ia.ep_ready = 1'b1;
    ia.key_value = 16'h0204; ia.key_request = 1'b1;
    add_exp(0, 16'h0204);
    step(1);
    ia.key_request = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (ia.ep_valid !== (k == 2)) begin
        bad++;
        $display("FAIL latency k=%0d: valid=%b need %b", k, ia.ep_valid, (k == 2));
      end
      if (k < 2) step(1);
    end
    total++;
    if (ia.ep_data !== 8'h02) begin
      bad++; $display("FAIL first_byte: data=%h need 02", ia.ep_data);
    end
    n = 0;
    while (ia.ep_valid === 1'b1 && n < 100) begin n++; step(1); end
    total++;
    if (n != 2*RLEN_A) begin
      bad++; $display("FAIL valid_len: %0d cycles need %0d", n, 2*RLEN_A);
    end
    total++;
    if (busy_a !== 1'b0) begin bad++; $display("FAIL single_idle: busy=%b need 0", busy_a); end
    total++;
    if (qa.size() != expa.size()) begin
      bad++; $display("FAIL single_len: %0d bytes need %0d", qa.size(), expa.size());
    end
    for (int i = 0; i < qa.size() && i < expa.size(); i++) begin
      total++;
      if (qa[i] !== expa[i]) begin bad++; $display("FAIL single_byte[%0d]: %h need %h", i, qa[i], expa[i]); end
    end
  endtask

  task automatic test_ready_toggle();
    int n;
    qa.delete(); expa.delete();
    ia.key_value = 16'h0005; ia.key_request = 1'b1; ia.ep_ready = 1'b1;
    add_exp(0, 16'h0005);
    step(1);
    ia.key_request = 1'b0;
    n = 0;
    while (busy_a === 1'b1 && n < 200) begin ia.ep_ready = ~ia.ep_ready; step(1); n++; end
    total++;
    if (busy_a !== 1'b0) begin bad++; $display("FAIL toggle_timeout: busy=%b need 0", busy_a); end
    total++;
    if (qa.size() != expa.size()) begin
      bad++; $display("FAIL toggle_len: %0d bytes need %0d", qa.size(), expa.size());
    end
    for (int i = 0; i < qa.size() && i < expa.size(); i++) begin
      total++;
      if (qa[i] !== expa[i]) begin bad++; $display("FAIL toggle_byte[%0d]: %h need %h", i, qa[i], expa[i]); end
    end
  endtask

  task automatic test_random_burst();
    int n, sent, cyc;
    logic [15:0] kv;
    for (int r = 0; r < 4; r++) begin
      qa.delete(); expa.delete();
      n = $urandom_range(3, 10); sent = 0; cyc = 0;
      while ((sent < n || busy_a === 1'b1) && cyc < 3000) begin
        ia.ep_ready = ($urandom % 4) != 0;
        if (sent < n && ($urandom % 2) == 1) begin
          kv = 16'($urandom);
          ia.key_value = kv; ia.key_request = 1'b1;
          add_exp(0, kv); sent++;
        end else begin
          ia.key_request = 1'b0;
        end
        step(1); cyc++;
      end
      ia.key_request = 1'b0;
      total++;
      if (cyc >= 3000) begin bad++; $display("FAIL rand_timeout: round %0d busy=%b", r, busy_a); end
      total++;
      if (qa.size() != expa.size()) begin
        bad++; $display("FAIL rand_len: round %0d %0d bytes need %0d", r, qa.size(), expa.size());
      end
      for (int i = 0; i < qa.size() && i < expa.size(); i++) begin
        total++;
        if (qa[i] !== expa[i]) begin bad++; $display("FAIL rand_byte[%0d]: %h need %h", i, qa[i], expa[i]); end
      end
      total++;
      if (drop_a !== 8'h00) begin bad++; $display("FAIL rand_drop: %0d need 0", drop_a); end
    end
    ia.ep_ready = 1'b1;
  endtask

  task automatic test_gap();
    bit ev, eb;
    qb.delete(); expb.delete();
    ib.ep_ready = 1'b1;
    ib.key_value = 16'h1122; ib.key_request = 1'b1;
    add_exp(1, 16'h1122);
    step(1);
    ib.key_request = 1'b0;
    for (int k = 0; k < 16; k++) begin
      ev = (k >= 2 && k < 2 + RLEN_B) || (k >= 2 + RLEN_B + GAP_B && k < 2 + 2*RLEN_B + GAP_B);
      eb = (k < 2 + 2*RLEN_B + GAP_B);
      total++;
      if (ib.ep_valid !== ev || busy_b !== eb) begin
        bad++;
        $display("FAIL gap k=%0d: valid=%b busy=%b need valid=%b busy=%b", k, ib.ep_valid, busy_b, ev, eb);
      end
      step(1);
    end
    total++;
    if (qb.size() != expb.size()) begin
      bad++; $display("FAIL gap_len: %0d bytes need %0d", qb.size(), expb.size());
    end
    for (int i = 0; i < qb.size() && i < expb.size(); i++) begin
      total++;
      if (qb[i] !== expb[i]) begin bad++; $display("FAIL gap_byte[%0d]: %h need %h", i, qb[i], expb[i]); end
    end
  endtask

  task automatic test_fifo_full();
    int outst, n;
    logic [15:0] kv;
    qb.delete(); expb.delete();
    ib.ep_ready = 1'b0; outst = 0;
    for (int i = 0; i < 6; i++) begin
      kv = {8'(i + 1), 8'(8'h10 + i)};
      ib.key_value = kv; ib.key_request = 1'b1;
      step(1);
      if (outst < DEPTH_B + 1) begin outst++; add_exp(1, kv); end
      else if (dropm_b < DMAX_B) dropm_b++;
      if (i >= 1) begin
        total++;
        if (ib.key_ready !== ((outst - 1) < DEPTH_B)) begin
          bad++; $display("FAIL full_kr push %0d: %b need %b", i + 1, ib.key_ready, ((outst - 1) < DEPTH_B));
        end
      end
    end
    ib.key_request = 1'b0;
    total++;
    if (drop_b !== 2'(dropm_b)) begin bad++; $display("FAIL full_drop: %0d need %0d", drop_b, dropm_b); end
    ib.ep_ready = 1'b1;
    n = 0;
    while (busy_b === 1'b1 && n < 500) begin step(1); n++; end
    total++;
    if (busy_b !== 1'b0) begin bad++; $display("FAIL full_timeout: busy=%b need 0", busy_b); end
    total++;
    if (qb.size() != expb.size()) begin
      bad++; $display("FAIL full_len: %0d bytes need %0d", qb.size(), expb.size());
    end
    for (int i = 0; i < qb.size() && i < expb.size(); i++) begin
      total++;
      if (qb[i] !== expb[i]) begin bad++; $display("FAIL full_byte[%0d]: %h need %h", i, qb[i], expb[i]); end
    end
  endtask

  task automatic test_drop_saturate();
    int outst, n;
    logic [15:0] kv;
    qb.delete(); expb.delete();
    ib.ep_ready = 1'b0; outst = 0;
    for (int i = 0; i < 10; i++) begin
      kv = 16'hA000 + 16'(i);
      ib.key_value = kv; ib.key_request = 1'b1;
      step(1);
      if (outst < DEPTH_B + 1) begin
        outst++; add_exp(1, kv);
      end else begin
        if (dropm_b < DMAX_B) dropm_b++;
        total++;
        if (drop_b !== 2'(dropm_b)) begin bad++; $display("FAIL sat_drop push %0d: %0d need %0d", i + 1, drop_b, dropm_b); end
      end
    end
    ib.key_request = 1'b0;
    ib.ep_ready = 1'b1;
    n = 0;
    while (busy_b === 1'b1 && n < 500) begin step(1); n++; end
    total++;
    if (busy_b !== 1'b0 || drop_b !== 2'(dropm_b)) begin
      bad++; $display("FAIL sat_drain: busy=%b drop=%0d need 0 %0d", busy_b, drop_b, dropm_b);
    end
    total++;
    if (qb.size() != expb.size()) begin
      bad++; $display("FAIL sat_len: %0d bytes need %0d", qb.size(), expb.size());
    end
    for (int i = 0; i < qb.size() && i < expb.size(); i++) begin
      total++;
      if (qb[i] !== expb[i]) begin bad++; $display("FAIL sat_byte[%0d]: %h need %h", i, qb[i], expb[i]); end
    end
  endtask

  task automatic test_usb_reset();
    int n;
    logic [15:0] kv;
    qb.delete(); expb.delete();
    ib.ep_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      kv = {8'(8'h40 + i), 8'(8'h20 + i)};
      ib.key_value = kv; ib.key_request = 1'b1;
      add_exp(1, kv);
      step(1);
    end
    ib.key_request = 1'b0;
    n = 0;
    while (qb.size() < 3 && n < 50) begin step(1); n++; end
    ib.ep_ready = 1'b0; usb_rstn_b = 1'b0;
    step(1);
    total++;
    if (ib.ep_valid !== 1'b0 || busy_b !== 1'b0 || ib.key_ready !== 1'b1 || drop_b !== 2'd0 || ib.ep_data !== 8'h00) begin
      bad++;
      $display("FAIL usbrst_flush: valid=%b busy=%b kr=%b drop=%0d data=%h need 0 0 1 0 00",
               ib.ep_valid, busy_b, ib.key_ready, drop_b, ib.ep_data);
    end
    dropm_b = 0;
    ib.key_value = 16'hFFFF; ib.key_request = 1'b1;
    step(1);
    ib.key_request = 1'b0;
    ib.ep_ready = 1'b1;
    step(3);
    total++;
    if (busy_b !== 1'b0 || drop_b !== 2'd0) begin
      bad++; $display("FAIL usbrst_ignore: busy=%b drop=%0d need 0 0", busy_b, drop_b);
    end
    total++;
    if (qb.size() != 3) begin bad++; $display("FAIL usbrst_bytes: %0d bytes need 3", qb.size()); end
    for (int i = 0; i < 3 && i < qb.size(); i++) begin
      total++;
      if (qb[i] !== expb[i]) begin bad++; $display("FAIL usbrst_pre[%0d]: %h need %h", i, qb[i], expb[i]); end
    end
    usb_rstn_b = 1'b1;
    qb.delete(); expb.delete();
    step(1);
    ib.key_value = 16'h0139; ib.key_request = 1'b1;
    add_exp(1, 16'h0139);
    step(1);
    ib.key_request = 1'b0;
    n = 0;
    while (busy_b === 1'b1 && n < 100) begin step(1); n++; end
    total++;
    if (qb.size() != expb.size()) begin
      bad++; $display("FAIL usbrst_len: %0d bytes need %0d", qb.size(), expb.size());
    end
    for (int i = 0; i < qb.size() && i < expb.size(); i++) begin
      total++;
      if (qb[i] !== expb[i]) begin bad++; $display("FAIL usbrst_byte[%0d]: %h need %h", i, qb[i], expb[i]); end
    end
  endtask

  initial begin
    ia.key_value = '0; ia.key_request = 1'b0; ia.ep_ready = 1'b0;
    ib.key_value = '0; ib.key_request = 1'b0; ib.ep_ready = 1'b0;
    test_reset();
    test_single_press();
    test_ready_toggle();
    test_random_burst();
    test_gap();
    test_fifo_full();
    test_drop_saturate();
    test_usb_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
